// File: rtl/uart_prog_loader_pkg.sv
// Shared types and constants for the UART program loader.
package uart_prog_loader_pkg;

    // Instruction word width, same as the CPU register width
    localparam int unsigned WORD_W           = 32;
    localparam int unsigned DEF_CLKS_PER_BIT = 868;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } load_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_prog_loader_if.sv
// Instruction-memory write port driven by the loader.
interface uart_prog_loader_if #(
    parameter int unsigned ADDR_W = 14
);
    import uart_prog_loader_pkg::*;

    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] wdata;

    modport master (output we, addr, wdata);
    modport slave  (input  we, addr, wdata);
endinterface

// File: rtl/uart_prog_loader_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, glitch reject.
module uart_prog_loader_rx
    import uart_prog_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    output logic       o_byte_valid,
    output logic [7:0] o_byte_data,
    output logic       o_frame_err_pulse
);
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF  = CLKS_PER_BIT / 2;

    logic             r_rx_meta;
    logic             r_rx_sync;
    logic             r_rx_prev;
    rx_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;

    // Synchronise the asynchronous line; keep one extra stage for edge detect
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // Frame FSM: start check at half bit, then one sample per bit time
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state           <= RX_IDLE;
            r_cnt             <= '0;
            r_bit             <= '0;
            r_shift           <= '0;
            o_byte_valid      <= 1'b0;
            o_byte_data       <= '0;
            o_frame_err_pulse <= 1'b0;
        end else begin
            o_byte_valid      <= 1'b0;
            o_frame_err_pulse <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    if (r_rx_prev && !r_rx_sync) begin
                        r_state <= RX_START;
                        r_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (r_cnt == CNT_W'(HALF - 1)) begin
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_state <= r_rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                        r_cnt   <= '0;
                        r_shift <= {r_rx_sync, r_shift[7:1]};
                        r_bit   <= r_bit + 1'b1;
                        if (r_bit == 3'd7) begin
                            r_state <= RX_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (r_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                        r_cnt   <= '0;
                        r_state <= RX_IDLE;
                        if (r_rx_sync) begin
                            o_byte_valid <= 1'b1;
                            o_byte_data  <= r_shift;
                        end else begin
                            o_frame_err_pulse <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_prog_loader.sv
// Boot loader: UART bytes -> little-endian words -> sequential imem writes.
module uart_prog_loader
    import uart_prog_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int unsigned ADDR_W       = 14,
    parameter int unsigned TIMEOUT      = 100000
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_rx,
    input  logic               i_prog_en,
    output logic               o_cpu_hold,
    uart_prog_loader_if.master m_imem,
    output logic [ADDR_W:0]    o_word_count,
    output logic               o_load_done,
    output logic               o_frame_err
);
    localparam int unsigned       IDLE_W    = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    logic              w_byte_valid;
    logic [7:0]        w_byte_data;
    logic              w_frame_err_pulse;
    logic              w_counting;
    logic              w_timeout;

    load_state_t       r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_byte_idx;
    logic [WORD_W-1:0] r_word;
    logic [IDLE_W-1:0] r_idle_cnt;

    uart_prog_loader_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_rx (
        .i_clk             (i_clk),
        .i_rst             (i_rst),
        .i_rx              (i_rx),
        .o_byte_valid      (w_byte_valid),
        .o_byte_data       (w_byte_data),
        .o_frame_err_pulse (w_frame_err_pulse)
    );

    // Timeout only runs once something has been received
    assign w_counting = (o_word_count != '0) || (r_byte_idx != '0);
    assign w_timeout  = w_counting && (r_idle_cnt == IDLE_W'(TIMEOUT - 1));

    // Loader FSM, byte assembler, address counter and idle timeout
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_addr        <= '0;
            r_byte_idx    <= '0;
            r_word        <= '0;
            r_idle_cnt    <= '0;
            o_cpu_hold    <= 1'b0;
            m_imem.we     <= 1'b0;
            m_imem.addr   <= '0;
            m_imem.wdata  <= '0;
            o_word_count  <= '0;
            o_load_done   <= 1'b0;
            o_frame_err   <= 1'b0;
        end else begin
            m_imem.we <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_prog_en) begin
                        r_state      <= ST_LOAD;
                        r_addr       <= '0;
                        r_byte_idx   <= '0;
                        r_word       <= '0;
                        r_idle_cnt   <= '0;
                        o_word_count <= '0;
                        o_frame_err  <= 1'b0;
                        o_cpu_hold   <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (!i_prog_en) begin
                        r_state    <= ST_IDLE;
                        o_cpu_hold <= 1'b0;
                    end else if (w_byte_valid) begin
                        r_idle_cnt <= '0;
                        if (r_byte_idx == 2'd3) begin
                            m_imem.we    <= 1'b1;
                            m_imem.addr  <= r_addr;
                            m_imem.wdata <= {w_byte_data, r_word[23:0]};
                            r_word       <= '0;
                            r_byte_idx   <= '0;
                            r_addr       <= r_addr + 1'b1;
                            o_word_count <= o_word_count + 1'b1;
                            if (r_addr == LAST_ADDR) begin
                                r_state     <= ST_DONE;
                                o_cpu_hold  <= 1'b0;
                                o_load_done <= 1'b1;
                            end
                        end else begin
                            r_word[{r_byte_idx, 3'b000} +: 8] <= w_byte_data;
                            r_byte_idx <= r_byte_idx + 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_idle_cnt <= '0;
                        if (r_byte_idx != '0) begin
                            r_state <= ST_FLUSH;
                        end else begin
                            r_state     <= ST_DONE;
                            o_cpu_hold  <= 1'b0;
                            o_load_done <= 1'b1;
                        end
                    end else if (w_counting) begin
                        r_idle_cnt <= r_idle_cnt + 1'b1;
                    end
                end
                ST_FLUSH: begin
                    // Unreceived upper lanes are already zero
                    m_imem.we    <= 1'b1;
                    m_imem.addr  <= r_addr;
                    m_imem.wdata <= r_word;
                    r_word       <= '0;
                    r_byte_idx   <= '0;
                    r_addr       <= r_addr + 1'b1;
                    o_word_count <= o_word_count + 1'b1;
                    r_state      <= ST_DONE;
                    o_cpu_hold   <= 1'b0;
                    o_load_done  <= 1'b1;
                end
                ST_DONE: begin
                    if (!i_prog_en) begin
                        r_state     <= ST_IDLE;
                        o_load_done <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            // A bad stop bit is never lost, even on the LOAD entry cycle
            if (w_frame_err_pulse) begin
                o_frame_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: byte-level model of the image load.
module tb_uart_prog_loader;
    import uart_prog_loader_pkg::*;

    localparam int unsigned CPB   = 8;
    localparam int unsigned AW    = 4;
    localparam int unsigned TMO   = 200;
    localparam int unsigned DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx;
    logic          prog_en;
    logic          cpu_hold;
    logic          load_done;
    logic          frame_err;
    logic [AW:0]   word_count;

    uart_prog_loader_if #(.ADDR_W(AW)) imem_if ();

    uart_prog_loader #(
        .CLKS_PER_BIT (CPB),
        .ADDR_W       (AW),
        .TIMEOUT      (TMO)
    ) u_dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_rx         (rx),
        .i_prog_en    (prog_en),
        .o_cpu_hold   (cpu_hold),
        .m_imem       (imem_if),
        .o_word_count (word_count),
        .o_load_done  (load_done),
        .o_frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    int   total = 0;
    int   bad   = 0;
    wr_t  exp_q[$];
    wr_t  log_q[$];

    // Behavioural model of the load
    bit         m_loading = 1'b0;
    bit         m_done    = 1'b0;
    logic [7:0] m_bytes[$];
    int         m_addr    = 0;
    int         m_wc      = 0;

    bit prev_we  = 1'b0;
    int bv_count = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_word();
        logic [31:0] w = '0;
        foreach (m_bytes[i]) w = w | (32'(m_bytes[i]) << (8 * i));
        return w;
    endfunction

    task automatic model_push_write();
        wr_t e;
        e.addr = AW'(m_addr);
        e.data = model_word();
        exp_q.push_back(e);
        m_bytes.delete();
        m_addr++;
        m_wc++;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (m_loading) begin
            m_bytes.push_back(b);
            if (m_bytes.size() == 4) begin
                model_push_write();
                if (m_addr == DEPTH) begin
                    m_loading = 1'b0;
                    m_done    = 1'b1;
                end
            end
        end
    endtask

    task automatic model_timeout();
        if (m_loading && (m_wc > 0 || m_bytes.size() > 0)) begin
            if (m_bytes.size() > 0) model_push_write();
            m_loading = 1'b0;
            m_done    = 1'b1;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        if (stop_ok) model_byte(b);
        rx = stop_ok;
        tick(CPB);
        rx = 1'b1;
        tick(4);
    endtask

    task automatic idle(input int n);
        if (n > int'(TMO) + 20) model_timeout();
        tick(n);
    endtask

    task automatic start_load(input string tag);
        prog_en   = 1'b1;
        m_loading = 1'b1;
        m_done    = 1'b0;
        m_bytes.delete();
        m_addr    = 0;
        m_wc      = 0;
        log_q.delete();
        tick(2);
        check({tag, "/hold_on_entry"}, 64'(cpu_hold), 64'(1));
        check({tag, "/wc_on_entry"}, 64'(word_count), 64'(0));
        check({tag, "/ferr_on_entry"}, 64'(frame_err), 64'(0));
    endtask

    task automatic stop_load(input string tag);
        prog_en   = 1'b0;
        m_loading = 1'b0;
        m_done    = 1'b0;
        tick(2);
        check({tag, "/done_cleared"}, 64'(load_done), 64'(0));
    endtask

    task automatic check_state(input string tag);
        check({tag, "/word_count"}, 64'(word_count), 64'(m_wc));
        check({tag, "/load_done"}, 64'(load_done), 64'(m_done));
        check({tag, "/cpu_hold"}, 64'(cpu_hold), 64'(m_loading));
        check({tag, "/writes_pending"}, 64'(exp_q.size()), 64'(0));
    endtask

    task automatic check_log(input string tag, input int idx, input logic [AW-1:0] a, input logic [31:0] d);
        if (idx >= log_q.size()) begin
            total++;
            bad++;
            $display("FAIL %s: write #%0d missing, got %0d writes want more", tag, idx, log_q.size());
        end else begin
            check({tag, "/addr"}, 64'(log_q[idx].addr), 64'(a));
            check({tag, "/data"}, 64'(log_q[idx].data), 64'(d));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "/cpu_hold"}, 64'(cpu_hold), 64'(0));
        check({tag, "/we"}, 64'(imem_if.we), 64'(0));
        check({tag, "/addr"}, 64'(imem_if.addr), 64'(0));
        check({tag, "/wdata"}, 64'(imem_if.wdata), 64'(0));
        check({tag, "/word_count"}, 64'(word_count), 64'(0));
        check({tag, "/load_done"}, 64'(load_done), 64'(0));
        check({tag, "/frame_err"}, 64'(frame_err), 64'(0));
    endtask

    // Every imem write is checked against the model's expected write stream
    always @(negedge clk) begin
        if (rst) begin
            prev_we = 1'b0;
        end else begin
            if (imem_if.we) begin
                wr_t cur;
                cur.addr = imem_if.addr;
                cur.data = imem_if.wdata;
                log_q.push_back(cur);
                total++;
                if (prev_we) begin
                    bad++;
                    $display("FAIL we_back_to_back: got we=1 on two cycles want single pulse");
                end
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got addr=%0d data=%08h want no write", cur.addr, cur.data);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("write_addr", 64'(cur.addr), 64'(e.addr));
                    check("write_data", 64'(cur.data), 64'(e.data));
                end
            end
            prev_we = imem_if.we;
        end
    end

    always @(posedge clk) begin
        if (u_dut.u_uart_rx.o_byte_valid) bv_count++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] img1 [8]  = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
        logic [7:0] img2 [6]  = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
        int c0;

        rst = 1'b1;
        rx = 1'b1;
        prog_en = 1'b0;
        tick(3);
        check_all_zero("reset");
        rst = 1'b0;
        tick(3);

        // Two full words, then timeout
        start_load("t1");
        for (int i = 0; i < 8; i++) begin
            send_byte(img1[i], 1'b1);
            if (i == 3) check_state("t1_mid");
        end
        check("t1/hold_during_bytes", 64'(cpu_hold), 64'(1));
        idle(250);
        check_state("t1_end");
        check_log("t1_w0", 0, 4'd0, 32'h00000513);
        check_log("t1_w1", 1, 4'd1, 32'h00100593);
        check("t1/done_literal", 64'(load_done), 64'(1));
        stop_load("t1");

        // Partial last word is flushed zero-filled
        start_load("t2");
        for (int i = 0; i < 6; i++) send_byte(img2[i], 1'b1);
        idle(250);
        check_state("t2_end");
        check_log("t2_w0", 0, 4'd0, 32'hDDCCBBAA);
        check_log("t2_w1", 1, 4'd1, 32'h00002211);
        check("t2/wc_literal", 64'(word_count), 64'(2));
        stop_load("t2");

        // Bad stop bit between two words
        start_load("t3");
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1);
        send_byte(8'hEE, 1'b0);
        check("t3/frame_err", 64'(frame_err), 64'(1));
        for (int i = 5; i <= 8; i++) send_byte(8'(i), 1'b1);
        idle(250);
        check_state("t3_end");
        check_log("t3_w0", 0, 4'd0, 32'h04030201);
        check_log("t3_w1", 1, 4'd1, 32'h08070605);
        check("t3/frame_err_sticky", 64'(frame_err), 64'(1));
        stop_load("t3");

        // Abort after two bytes of a word, with frame_err set
        start_load("t5");
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b1);
        send_byte(8'h5A, 1'b0);
        send_byte(8'h77, 1'b1);
        send_byte(8'h88, 1'b1);
        prog_en = 1'b0;
        m_loading = 1'b0;
        m_bytes.delete();
        tick(1);
        check("t5/hold_drop", 64'(cpu_hold), 64'(0));
        tick(260);
        check_state("t5_aborted");
        check("t5/ferr_kept", 64'(frame_err), 64'(1));
        start_load("t5_reload");
        stop_load("t5_reload");

        // Full memory: 64 bytes end the load without timeout
        start_load("t4");
        for (int i = 0; i < 64; i++) send_byte(8'($urandom), 1'b1);
        check_state("t4_full");
        check("t4/done_literal", 64'(load_done), 64'(1));
        check("t4/wc_literal", 64'(word_count), 64'(16));
        if (log_q.size() == 16) check("t4/last_addr", 64'(log_q[15].addr), 64'(15));
        else check("t4/write_count", 64'(log_q.size()), 64'(16));
        send_byte(8'hC3, 1'b1);
        idle(20);
        check_state("t4_extra_byte");
        stop_load("t4");

        // Random image lengths
        for (int k = 0; k < 3; k++) begin
            int n;
            start_load("rnd");
            n = int'($urandom_range(1, 20));
            for (int i = 0; i < n; i++) send_byte(8'($urandom), 1'b1);
            idle(TMO + 60);
            check_state("rnd_end");
            stop_load("rnd");
        end

        // Reset in the middle of byte 3, then an rx glitch
        start_load("t6");
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        rx = 1'b0;
        tick(CPB);
        rx = 1'b1;
        tick(CPB / 2);
        rst = 1'b1;
        prog_en = 1'b0;
        m_loading = 1'b0;
        m_done = 1'b0;
        m_bytes.delete();
        m_wc = 0;
        tick(1);
        check_all_zero("t6_reset");
        rst = 1'b0;
        tick(5);
        c0 = bv_count;
        rx = 1'b0;
        tick(2);
        rx = 1'b1;
        tick(40);
        check("t6/glitch_no_byte", 64'(bv_count - c0), 64'(0));
        check_state("t6_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
